emac_tx_frame_arbiter: RTL and testbench

- Frame-granular round-robin arbiter sharing the EMAC transmit AXI-S FIFO port (8-bit tdata/tvalid/tready/tlast, cpu_clk domain) between two requesters.
- Typical requesters: CPU packet path and a hardware responder.
- Enforces whole-frame ownership, so no interleaving ever occurs.
- Guards against runaway frames with a maximum-length truncation.

---
 rtl/emac_tx_arb_pkg.sv | 21 ++
 rtl/emac_tx_arb_rr.sv | 30 +++
 rtl/emac_tx_frame_arbiter.sv | 177 +++++++++++++++++
 tb/tb_emac_tx_frame_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emac_tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// emac_tx_arb_pkg
// Shared types and constants for the EMAC transmit frame arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE / XFER / DRAIN)
//   REQ0 / REQ1 : requester ids, also used as the round-robin pointer value
//   AXIS_DW     : AXI-Stream data width toward the EMAC tx FIFO
// -----------------------------------------------------------------------------
package emac_tx_arb_pkg;

    localparam int AXIS_DW = 8;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

endpackage

// File: rtl/emac_tx_arb_rr.sv
// -----------------------------------------------------------------------------
// emac_tx_arb_rr
// Two-way round-robin pick, purely combinational.
// The pointer holds the id of the requester served last; the other requester
// has priority when both are valid.
// Ports:
//   i_valid  [1:0] : request vector, bit n = requester n valid
//   i_rr_ptr       : id of the requester served last
//   o_pick   [1:0] : one-hot winner, 00 when nothing is valid
// -----------------------------------------------------------------------------
module emac_tx_arb_rr
    import emac_tx_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_rr_ptr,
    output logic [1:0] o_pick
);

    always_comb begin
        o_pick = 2'b00;
        if (i_rr_ptr == REQ1) begin
            if (i_valid[REQ0])      o_pick = 2'b01;
            else if (i_valid[REQ1]) o_pick = 2'b10;
        end else begin
            if (i_valid[REQ1])      o_pick = 2'b10;
            else if (i_valid[REQ0]) o_pick = 2'b01;
        end
    end

endmodule

// File: rtl/emac_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// emac_tx_frame_arbiter
// Frame-granular round-robin arbiter sharing the EMAC tx AXI-S FIFO port
// between two requesters. A grant covers a whole frame, so frames never
// interleave. Frames longer than MAX_FRAME_LEN beats are cut: the beat at
// MAX_FRAME_LEN carries a forced tlast, overlong pulses, and the rest of the
// source frame is consumed and discarded.
//
// Optional build macro: EMAC_TX_STATS_EN adds per-requester completed-frame
// counters (frame_cnt0 / frame_cnt1, 16-bit, wrapping).
//
// Ports:
//   cpu_clk, cpu_rstn       : clock, async active-low reset
//   tx_en                   : allow new grants (a running frame always finishes)
//   s0_* / s1_*             : requester AXI-S slave ports (tdata/tvalid/tready/tlast)
//   m_*                     : AXI-S master port toward the EMAC tx FIFO
//   grant                   : one-hot owner, 00 when idle (registered)
//   busy                    : high in XFER or DRAIN (registered)
//   overlong                : one-cycle pulse after a truncated beat
//   frame_cnt0/1            : completed frames per requester (EMAC_TX_STATS_EN)
//
// state | meaning
// IDLE  | no owner; arbitrate when tx_en and a requester is valid
// XFER  | owner's stream passed through combinationally to the EMAC
// DRAIN | frame truncated; owner's remaining beats accepted and dropped
// -----------------------------------------------------------------------------
module emac_tx_frame_arbiter
    import emac_tx_arb_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 1518
) (
    input  logic               cpu_clk,
    input  logic               cpu_rstn,
    input  logic               tx_en,
    input  logic [AXIS_DW-1:0] s0_tdata,
    input  logic               s0_tvalid,
    output logic               s0_tready,
    input  logic               s0_tlast,
    input  logic [AXIS_DW-1:0] s1_tdata,
    input  logic               s1_tvalid,
    output logic               s1_tready,
    input  logic               s1_tlast,
    output logic [AXIS_DW-1:0] m_tdata,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic               m_tlast,
    output logic [1:0]         grant,
    output logic               busy,
    output logic               overlong
`ifdef EMAC_TX_STATS_EN
    ,
    output logic [15:0]        frame_cnt0,
    output logic [15:0]        frame_cnt1
`endif
);

    localparam int               CNT_W    = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_FRAME_LEN - 1);

    arb_state_e       r_state;
    logic             r_rr_ptr;
    logic             r_sel;
    logic [1:0]       r_grant;
    logic             r_busy;
    logic             r_overlong;
    logic [CNT_W-1:0] r_beat_cnt;
`ifdef EMAC_TX_STATS_EN
    logic [15:0]      r_frame_cnt0;
    logic [15:0]      r_frame_cnt1;
`endif

    logic [AXIS_DW-1:0] w_sel_tdata;
    logic               w_sel_tvalid;
    logic               w_sel_tlast;
    logic               w_sel_tready;
    logic               w_in_xfer;
    logic               w_in_drain;
    logic               w_at_limit;
    logic               w_accept;
    logic               w_frame_done;
    logic [1:0]         w_pick;

    // Selection follows the registered owner id, so the mux never switches
    // mid-frame even if the other requester becomes valid.
    assign w_sel_tdata  = (r_sel == REQ1) ? s1_tdata  : s0_tdata;
    assign w_sel_tvalid = (r_sel == REQ1) ? s1_tvalid : s0_tvalid;
    assign w_sel_tlast  = (r_sel == REQ1) ? s1_tlast  : s0_tlast;

    assign w_in_xfer  = (r_state == ST_XFER);
    assign w_in_drain = (r_state == ST_DRAIN);
    assign w_at_limit = (r_beat_cnt == LAST_IDX);
    assign w_accept   = w_in_xfer & w_sel_tvalid & m_tready;

    // A frame ends on the owner's real tlast, either as a passed-through beat
    // or as a discarded beat while draining a truncated frame.
    assign w_frame_done = (w_accept & w_sel_tlast)
                        | (w_in_drain & w_sel_tvalid & w_sel_tlast);

    // DRAIN swallows the owner's beats regardless of the EMAC side.
    assign w_sel_tready = w_in_xfer ? m_tready : w_in_drain;

    assign s0_tready = w_sel_tready & (r_sel == REQ0);
    assign s1_tready = w_sel_tready & (r_sel == REQ1);

    assign m_tvalid = w_in_xfer & w_sel_tvalid;
    assign m_tdata  = w_in_xfer ? w_sel_tdata : '0;
    assign m_tlast  = m_tvalid & (w_sel_tlast | w_at_limit);

    assign grant    = r_grant;
    assign busy     = r_busy;
    assign overlong = r_overlong;
`ifdef EMAC_TX_STATS_EN
    assign frame_cnt0 = r_frame_cnt0;
    assign frame_cnt1 = r_frame_cnt1;
`endif

    emac_tx_arb_rr u_rr (
        .i_valid  ({s1_tvalid, s0_tvalid}),
        .i_rr_ptr (r_rr_ptr),
        .o_pick   (w_pick)
    );

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= REQ1;
            r_sel        <= REQ0;
            r_grant      <= 2'b00;
            r_busy       <= 1'b0;
            r_overlong   <= 1'b0;
            r_beat_cnt   <= '0;
`ifdef EMAC_TX_STATS_EN
            r_frame_cnt0 <= '0;
            r_frame_cnt1 <= '0;
`endif
        end else begin
            r_overlong <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_en && (w_pick != 2'b00)) begin
                        r_grant <= w_pick;
                        r_sel   <= w_pick[1];
                        r_busy  <= 1'b1;
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_accept && !w_sel_tlast) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        if (w_at_limit) begin
                            r_overlong <= 1'b1;
                            r_state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_frame_done) begin
                r_state    <= ST_IDLE;
                r_grant    <= 2'b00;
                r_busy     <= 1'b0;
                r_rr_ptr   <= r_sel;
                r_beat_cnt <= '0;
`ifdef EMAC_TX_STATS_EN
                if (r_sel == REQ1) r_frame_cnt1 <= r_frame_cnt1 + 16'd1;
                else               r_frame_cnt0 <= r_frame_cnt0 + 16'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_emac_tx_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_emac_tx_frame_arbiter
// Frame-level scoreboard: every frame pushed to a requester is recorded both as
// the beats the source will offer and as the beats the EMAC side should see
// (cut at MAX_FRAME_LEN with a forced last). Output beats are matched against
// the owner's expected queue; arbitration order is checked per directed step.
// -----------------------------------------------------------------------------
module tb_emac_tx_frame_arbiter;

    localparam int MAXLEN = 1518;

    logic       cpu_clk = 1'b0;
    logic       cpu_rstn;
    logic       tx_en;
    logic [7:0] s0_tdata, s1_tdata, m_tdata;
    logic       s0_tvalid, s0_tready, s0_tlast;
    logic       s1_tvalid, s1_tready, s1_tlast;
    logic       m_tvalid, m_tready, m_tlast;
    logic [1:0] grant;
    logic       busy, overlong;
`ifdef EMAC_TX_STATS_EN
    logic [15:0] frame_cnt0, frame_cnt1;
`endif

    always #5 cpu_clk = ~cpu_clk;

    emac_tx_frame_arbiter #(.MAX_FRAME_LEN(MAXLEN)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rstn  (cpu_rstn),
        .tx_en     (tx_en),
        .s0_tdata  (s0_tdata),
        .s0_tvalid (s0_tvalid),
        .s0_tready (s0_tready),
        .s0_tlast  (s0_tlast),
        .s1_tdata  (s1_tdata),
        .s1_tvalid (s1_tvalid),
        .s1_tready (s1_tready),
        .s1_tlast  (s1_tlast),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .grant     (grant),
        .busy      (busy),
        .overlong  (overlong)
`ifdef EMAC_TX_STATS_EN
        ,
        .frame_cnt0 (frame_cnt0),
        .frame_cnt1 (frame_cnt1)
`endif
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       f;
    } beat_t;

    beat_t src0[$], src1[$], exp0[$], exp1[$];
    int    order[$];

    int   n_vec = 0;
    int   n_err = 0;
    int   p0 = 100, p1 = 100;
    int   mr_mode = 0;
    int   mr_pct = 100;
    logic exp_ovl = 1'b0;
    int   cur_owner = -1;
    int   n_out = 0;
    int   n_ovl_seen = 0;
    int   cyc = 0;
    int   done0 = 0, done1 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int req, input int len);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            beat_t e;
            b.d = 8'($urandom);
            b.l = (i == len - 1);
            b.f = 1'b0;
            if (req == 0) src0.push_back(b); else src1.push_back(b);
            if (i < MAXLEN) begin
                e   = b;
                e.l = b.l || (i == MAXLEN - 1);
                e.f = (i == MAXLEN - 1) && (len > MAXLEN);
                if (req == 0) exp0.push_back(e); else exp1.push_back(e);
            end
        end
        if (req == 0) done0++; else done1++;
    endtask

    task automatic cycle();
        beat_t e;
        int    own;
        @(negedge cpu_clk);
        cyc++;
        if (src0.size() > 0 && $urandom_range(99) < p0) begin
            s0_tvalid = 1'b1; s0_tdata = src0[0].d; s0_tlast = src0[0].l;
        end else begin
            s0_tvalid = 1'b0; s0_tdata = 8'($urandom); s0_tlast = 1'($urandom);
        end
        if (src1.size() > 0 && $urandom_range(99) < p1) begin
            s1_tvalid = 1'b1; s1_tdata = src1[0].d; s1_tlast = src1[0].l;
        end else begin
            s1_tvalid = 1'b0; s1_tdata = 8'($urandom); s1_tlast = 1'($urandom);
        end
        case (mr_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = cyc[0];
            default: m_tready = ($urandom_range(99) < mr_pct);
        endcase
        #1;
        chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
        chk("busy_vs_grant", 32'(busy), 32'(grant != 2'b00));
        chk("overlong_pulse", 32'(overlong), 32'(exp_ovl));
        if (overlong) n_ovl_seen++;
        if (grant == 2'b00) begin
            chk("idle_s0_tready", 32'(s0_tready), 32'd0);
            chk("idle_s1_tready", 32'(s1_tready), 32'd0);
            chk("idle_m_tvalid", 32'(m_tvalid), 32'd0);
        end else if (grant == 2'b01) begin
            chk("ungranted_s1_tready", 32'(s1_tready), 32'd0);
            if (m_tvalid) begin
                chk("pass_tdata0", 32'(m_tdata), 32'(s0_tdata));
                chk("pass_tvalid0", 32'(s0_tvalid), 32'd1);
                chk("mirror_tready0", 32'(s0_tready), 32'(m_tready));
            end
        end else begin
            chk("ungranted_s0_tready", 32'(s0_tready), 32'd0);
            if (m_tvalid) begin
                chk("pass_tdata1", 32'(m_tdata), 32'(s1_tdata));
                chk("pass_tvalid1", 32'(s1_tvalid), 32'd1);
                chk("mirror_tready1", 32'(s1_tready), 32'(m_tready));
            end
        end
        exp_ovl = 1'b0;
        if (s0_tvalid && s0_tready) begin
            chk("consume_owner0", 32'(grant), 32'd1);
            e = src0.pop_front();
        end
        if (s1_tvalid && s1_tready) begin
            chk("consume_owner1", 32'(grant), 32'd2);
            e = src1.pop_front();
        end
        if (m_tvalid && m_tready) begin
            own = grant[1] ? 1 : 0;
            n_out++;
            if (cur_owner >= 0) chk("no_interleave", 32'(own), 32'(cur_owner));
            e.d = 'x; e.l = 'x; e.f = 1'b0;
            if (own == 0 && exp0.size() > 0) e = exp0.pop_front();
            if (own == 1 && exp1.size() > 0) e = exp1.pop_front();
            chk("beat_data", 32'(m_tdata), 32'(e.d));
            chk("beat_last", 32'(m_tlast), 32'(e.l));
            exp_ovl = e.f;
            if (m_tlast) begin
                order.push_back(own);
                cur_owner = -1;
            end else begin
                cur_owner = own;
            end
        end
    endtask

    task automatic run_idle(input int budget, input string tag);
        int n;
        n = 0;
        while ((src0.size() > 0 || src1.size() > 0 || exp0.size() > 0 ||
                exp1.size() > 0 || grant != 2'b00) && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_complete_in_budget"}, 32'(n < budget), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge cpu_clk);
        cpu_rstn = 1'b0;
        #1;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_s0_tready", 32'(s0_tready), 32'd0);
        chk("rst_s1_tready", 32'(s1_tready), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overlong", 32'(overlong), 32'd0);
`ifdef EMAC_TX_STATS_EN
        chk("rst_frame_cnt0", 32'(frame_cnt0), 32'd0);
        chk("rst_frame_cnt1", 32'(frame_cnt1), 32'd0);
`endif
        src0.delete(); src1.delete(); exp0.delete(); exp1.delete(); order.delete();
        cur_owner = -1; exp_ovl = 1'b0; done0 = 0; done1 = 0;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; s0_tlast = 1'b0; s1_tlast = 1'b0;
        repeat (2) @(negedge cpu_clk);
        cpu_rstn = 1'b1;
    endtask

    initial begin
        int base;
        int obase;
        int n;
        cpu_rstn  = 1'b0;
        tx_en     = 1'b1;
        s0_tdata  = 8'h00; s0_tvalid = 1'b0; s0_tlast = 1'b0;
        s1_tdata  = 8'h00; s1_tvalid = 1'b0; s1_tlast = 1'b0;
        m_tready  = 1'b1;

        do_reset();

        // 60-beat frame from s0, grant latency and completion
        base = n_out;
        push_frame(0, 60);
        cycle();
        chk("t1_grant_before", 32'(grant), 32'd0);
        chk("t1_s0_tready_before", 32'(s0_tready), 32'd0);
        cycle();
        chk("t1_grant_latency", 32'(grant), 32'd1);
        chk("t1_first_ready", 32'(s0_tready), 32'd1);
        run_idle(200, "t1");
        chk("t1_beats", 32'(n_out - base), 32'd60);
        chk("t1_frames", 32'(order.size()), 32'd1);
        chk("t1_owner", 32'(order[0]), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // both valid from reset: strict alternation starting with s0
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_frame(0, 4);
            push_frame(1, 4);
        end
        run_idle(300, "t2");
        chk("t2_frames", 32'(order.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk("t2_order", 32'(order[i]), 32'(i % 2));

        // runaway 2000-beat frame from s1
        order.delete();
        base  = n_out;
        obase = n_ovl_seen;
        push_frame(1, 2000);
        run_idle(3000, "t3");
        chk("t3_beats_out", 32'(n_out - base), 32'(MAXLEN));
        chk("t3_overlong_pulses", 32'(n_ovl_seen - obase), 32'd1);
        chk("t3_frames", 32'(order.size()), 32'd1);

        // exactly MAXLEN beats: normal completion
        base  = n_out;
        obase = n_ovl_seen;
        push_frame(0, MAXLEN);
        run_idle(2000, "t4");
        chk("t4_beats_out", 32'(n_out - base), 32'(MAXLEN));
        chk("t4_no_overlong", 32'(n_ovl_seen - obase), 32'd0);

        // m_tready toggling during a 10-beat frame
        mr_mode = 1;
        base = n_out;
        push_frame(0, 10);
        run_idle(100, "t5");
        chk("t5_beats_out", 32'(n_out - base), 32'd10);
        mr_mode = 0;

        // tx_en dropped mid-frame with s1 pending
        do_reset();
        push_frame(0, 10);
        push_frame(1, 5);
        base = n_out;
        n = 0;
        while (n_out - base < 3 && n < 50) begin cycle(); n++; end
        chk("t6_reach_beat3", 32'(n_out - base >= 3), 32'd1);
        tx_en = 1'b0;
        n = 0;
        while (exp0.size() > 0 && n < 100) begin cycle(); n++; end
        repeat (20) cycle();
        chk("t6_s0_finished", 32'(exp0.size()), 32'd0);
        chk("t6_grant_held_idle", 32'(grant), 32'd0);
        chk("t6_s1_pending", 32'(exp1.size()), 32'd5);
        tx_en = 1'b1;
        run_idle(100, "t6");
        chk("t6_frames", 32'(order.size()), 32'd2);
        chk("t6_order0", 32'(order[0]), 32'd0);
        chk("t6_order1", 32'(order[1]), 32'd1);

        // reset mid-frame after s0 was served last
        order.delete();
        push_frame(0, 4);
        run_idle(100, "t7a");
        push_frame(0, 10);
        base = n_out;
        n = 0;
        while (n_out - base < 5 && n < 50) begin cycle(); n++; end
        chk("t7_reach_beat5", 32'(n_out - base >= 5), 32'd1);
        do_reset();
        push_frame(1, 3);
        push_frame(0, 3);
        run_idle(100, "t7");
        chk("t7_frames", 32'(order.size()), 32'd2);
        chk("t7_first_owner", 32'(order[0]), 32'd0);
        chk("t7_second_owner", 32'(order[1]), 32'd1);

        // randomized traffic with throttled sources and sink
        mr_mode = 2;
        for (int r = 0; r < 30; r++) begin
            p0     = int'($urandom_range(100, 30));
            p1     = int'($urandom_range(100, 30));
            mr_pct = int'($urandom_range(100, 30));
            for (int k = 0; k < int'($urandom_range(3, 1)); k++)
                push_frame(0, int'($urandom_range(40, 1)));
            for (int k = 0; k < int'($urandom_range(3, 1)); k++)
                push_frame(1, int'($urandom_range(40, 1)));
            run_idle(3000, "t8");
        end
        mr_mode = 0; p0 = 100; p1 = 100;

`ifdef EMAC_TX_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) push_frame(0, 8);
        push_frame(1, 1600);
        run_idle(4000, "t9");
        chk("t9_frame_cnt0", 32'(frame_cnt0), 32'(done0));
        chk("t9_frame_cnt1", 32'(frame_cnt1), 32'(done1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
